riscv_mem_arbiter: RTL

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter that funnels several memory requesters onto one
// downstream port. Outstanding accesses are tracked so that responses
// always return, in order, to the port that issued them.
module riscv_mem_arbiter #(
  parameter int PORTS       = 2,
  parameter int DBITS       = 64,
  parameter int MAX_PENDING = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   ena_i,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS*DBITS-1:0] d_i,
  output logic [PORTS-1:0]       ack_o,
  output logic                   req_o,
  output logic [DBITS-1:0]       q_o,
  input  logic                   ack_i,
  output logic [PORTS-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int IW = $clog2(PORTS);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);
  localparam logic [7:0]    BURST_MAX = 8'(MAX_BURST);
  localparam logic [IW-1:0] LAST_RST  = IW'(PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   pending, pending_next;
  logic [7:0]      burst, burst_next;
  logic [PORTS-1:0] grant, grant_next;
  logic [IW-1:0]   last_grant, last_next;
  logic [IW-1:0]   sel;
  logic            found;
  int              cand;
  logic            active, owner_req, others_req, ack_ok, issue;

  // Round-robin search starting just above the previous owner, wrapping around.
  always_comb begin
    sel   = last_grant;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = (int'(last_grant) + i) % PORTS;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = IW'(cand);
      end
    end
  end

  // Qualify downstream issue and completion; last_grant doubles as the owner index.
  always_comb begin
    active     = ena_i & ~clr_i;
    owner_req  = req_i[last_grant];
    others_req = |(req_i & ~grant);
    ack_ok     = ack_i & active & (pending != '0);
    issue      = (state == BUSY) & owner_req & active & ((pending < PEND_MAX) | ack_i);
  end

  // Next-state logic: counters, FSM transitions, grant/owner updates.
  always_comb begin
    pending_next = pending;
    burst_next   = burst;
    state_next   = state;
    grant_next   = grant;
    last_next    = last_grant;

    if (issue && !ack_ok) begin
      pending_next = pending + PEND_ONE;
    end else if (ack_ok && !issue) begin
      pending_next = pending - PEND_ONE;
    end

    if (issue && burst != 8'hFF) begin
      burst_next = burst + 8'd1;
    end

    if (clr_i) begin
      state_next   = IDLE;
      pending_next = '0;
      burst_next   = '0;
    end else if (ena_i) begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            last_next       = sel;
            grant_next      = '0;
            grant_next[sel] = 1'b1;
            burst_next      = '0;
            state_next      = BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state_next = (pending_next != '0) ? DRAIN : IDLE;
          end else if (burst_next >= BURST_MAX && others_req) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (pending_next == '0) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (state_next == IDLE) begin
      grant_next = '0;
    end
  end

  // State register; reset hands the first arbitration to port 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pending    <= '0;
      burst      <= '0;
      grant      <= '0;
      last_grant <= LAST_RST;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      burst      <= burst_next;
      grant      <= grant_next;
      last_grant <= last_next;
    end
  end

  // Output routing: completion goes to the current owner only.
  always_comb begin
    req_o   = issue;
    ack_o   = ack_ok ? grant : '0;
    grant_o = grant;
    busy_o  = (state != IDLE);
    q_o     = (state != IDLE) ? d_i[int'(last_grant)*DBITS +: DBITS] : '0;
  end

endmodule
